mem_ctrl: RTL
=============

Name: mem_ctrl

Overview:
- Arbitrates the single byte-wide synchronous RAM between the instruction-fetch stage (32-bit reads) and the memory stage (byte/half/word loads and stores).
- Sequences each request as consecutive byte accesses and assembles or splits 32-bit words little-endian.
- Returns a one-cycle ready pulse to the requester.
- Sits between stage_if/stage_mem and the top-level RAM port.

Parameters:
- ADDR_W, 17, RAM byte-address width; upper request-address bits are ignored.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset (reset==0 resets on clk edge)
- if_read  in  1  fetch request; held high until if_ready
- if_addr  in  32  fetch address
- if_ready  out  1  one-cycle pulse; if_data valid this cycle
- if_data  out  32  fetched instruction, little-endian
- mem_read  in  1  load request; held until mem_ready
- mem_write  in  1  store request; held until mem_ready
- mem_addr  in  32  load/store address
- mem_len  in  2  0=byte, 1=half, 3=word (2 treated as word)
- mem_wdata  in  32  store data; low bytes used
- mem_ready  out  1  one-cycle completion pulse
- mem_rdata  out  32  load data, zero-extended; sign extension belongs to the MEM stage
- ram_rw  out  1  1=write, 0=read
- ram_addr  out  ADDR_W  RAM byte address
- ram_dout  out  8  write byte
- ram_din  in  8  read byte, valid the cycle after its address is driven

Behaviour:
- Reset values: if_ready=0, mem_ready=0, if_data=0, mem_rdata=0, ram_rw=0, ram_addr=0, ram_dout=0. State goes to IDLE and the byte counter to 0.
- States: IDLE, READ, WRITE, DONE.
- IDLE arbitration (sampled each edge), in priority order:
  - mem_write → WRITE
  - else mem_read → READ (owner MEM)
  - else if_read → READ (owner IF, 4 bytes)
  - MEM always beats IF; no fairness.
  - mem_read and mem_write together: treated as a write.
- Captured at grant: base address, byte count N (1/2/4), write data, owner. Later changes on the request inputs are ignored, except withdrawal.
- READ, request accepted at edge T:
  - Byte k address (base+k, mod 2^ADDR_W) is driven during cycle T+1+k, ram_rw=0.
  - ram_din is captured into byte lane k at edge T+2+k.
  - After the last capture the state goes to DONE. The owner's ready is high during cycle T+N+2 with data stable.
  - Word fetch latency: 6 cycles from request to ready.
- WRITE, accepted at edge T:
  - During cycle T+1+k: ram_rw=1, ram_addr=base+k, ram_dout=wdata[8k+7:8k].
  - mem_ready is high in cycle T+N+1.
  - ram_rw returns to 0 after the last byte.
- DONE: ready high for exactly one cycle, then IDLE.
  - Requesters drop their request at the ready edge.
  - A new request seen in the IDLE cycle after DONE is granted normally: one bubble cycle between transactions.
- Unused read lanes are 0. if_data and mem_rdata hold their last value until the next completion for that owner.
- Withdrawal: if the owner deasserts its read request during READ (e.g. a branch flush), the transfer aborts at the next edge. State goes to IDLE, no ready pulse, and the output data registers are unchanged.
- Writes are never aborted; mem_write must stay high until mem_ready.
- Address wrap: base+k wraps modulo 2^ADDR_W.
- Reset mid-transfer: immediate return to IDLE, no ready pulse, and any partial write is left in RAM as-is.
- When not in READ or WRITE: ram_rw=0. ram_addr holds its last value.

Test Plan:
- Word fetch: if_read=1, if_addr=0x100, RAM[0x100..0x103]=13,05,00,00 → ram_addr 0x100..0x103 over 4 cycles; if_ready pulses 6 cycles after the request with if_data=0x00000513; mem_ready stays 0.
- Store half: mem_write=1, mem_addr=0x2000, mem_len=1, mem_wdata=0xDEADBEEF → two cycles with ram_rw=1 writing 0xEF@0x2000 and 0xBE@0x2001; mem_ready pulses 3 cycles after the request; RAM[0x2002] is untouched.
- Contention: if_read and mem_read (len=0, addr 0x10, RAM=0x80) rise on the same edge → MEM served first with mem_rdata=0x00000080; IF granted in the IDLE cycle after mem_ready; both complete exactly once.
- Flush: if_read dropped 2 cycles after grant → no if_ready; a fetch at 0x200 issued the next cycle completes correctly; if_data is unchanged before that completion.
- Wrap: word read at address 0x1FFFE with ADDR_W=17 → ram_addr sequence 0x1FFFE, 0x1FFFF, 0x00000, 0x00001.
- Reset mid-write: reset=0 after the second byte of a word store → only 2 bytes written, no mem_ready, all outputs at reset values the next cycle.

Source files
------------

// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller: arbitrates instruction fetch and MEM-stage load/store
// onto one byte-wide synchronous RAM, assembling/splitting 32-bit words little-endian.
module mem_ctrl #(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_read,
    input  logic [31:0]       if_addr,
    output logic              if_ready,
    output logic [31:0]       if_data,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [31:0]       mem_addr,
    input  logic [1:0]        mem_len,
    input  logic [31:0]       mem_wdata,
    output logic              mem_ready,
    output logic [31:0]       mem_rdata,
    output logic              ram_rw,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t              r_state;
    logic [2:0]          r_cnt;
    logic [2:0]          r_len;
    logic                r_own_mem;
    logic [31:0]         r_wdata;
    logic [31:0]         r_buf;
    logic                r_if_ready;
    logic                r_mem_ready;
    logic [31:0]         r_if_data;
    logic [31:0]         r_mem_rdata;
    logic                r_rw;
    logic [ADDR_W-1:0]   r_addr;
    logic [7:0]          r_dout;

    logic [2:0]          w_len;
    logic [31:0]         w_word;
    logic [7:0]          w_next_byte;
    logic                w_owner_req;

    assign if_ready  = r_if_ready;
    assign mem_ready = r_mem_ready;
    assign if_data   = r_if_data;
    assign mem_rdata = r_mem_rdata;
    assign ram_rw    = r_rw;
    assign ram_addr  = r_addr;
    assign ram_dout  = r_dout;

    assign w_owner_req = r_own_mem ? mem_read : if_read;

    always_comb begin
        w_len = 3'd4;
        case (mem_len)
            2'd0:    w_len = 3'd1;
            2'd1:    w_len = 3'd2;
            default: w_len = 3'd4;
        endcase
    end

    // ram_din arriving now belongs to the byte addressed one cycle earlier (lane r_cnt-1)
    always_comb begin
        w_word = r_buf;
        case (r_cnt)
            3'd1:    w_word[7:0]   = ram_din;
            3'd2:    w_word[15:8]  = ram_din;
            3'd3:    w_word[23:16] = ram_din;
            3'd4:    w_word[31:24] = ram_din;
            default: w_word        = r_buf;
        endcase
    end

    always_comb begin
        w_next_byte = r_wdata[31:24];
        case (r_cnt)
            3'd0:    w_next_byte = r_wdata[15:8];
            3'd1:    w_next_byte = r_wdata[23:16];
            default: w_next_byte = r_wdata[31:24];
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cnt       <= 3'd0;
            r_len       <= 3'd0;
            r_own_mem   <= 1'b0;
            r_wdata     <= 32'd0;
            r_buf       <= 32'd0;
            r_if_ready  <= 1'b0;
            r_mem_ready <= 1'b0;
            r_if_data   <= 32'd0;
            r_mem_rdata <= 32'd0;
            r_rw        <= 1'b0;
            r_addr      <= '0;
            r_dout      <= 8'd0;
        end else begin
            r_if_ready  <= 1'b0;
            r_mem_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt <= 3'd0;
                    r_buf <= 32'd0;
                    if (mem_write) begin
                        r_state   <= WRITE;
                        r_len     <= w_len;
                        r_own_mem <= 1'b1;
                        r_wdata   <= mem_wdata;
                        r_rw      <= 1'b1;
                        r_addr    <= mem_addr[ADDR_W-1:0];
                        r_dout    <= mem_wdata[7:0];
                    end else if (mem_read) begin
                        r_state   <= READ;
                        r_len     <= w_len;
                        r_own_mem <= 1'b1;
                        r_addr    <= mem_addr[ADDR_W-1:0];
                    end else if (if_read) begin
                        r_state   <= READ;
                        r_len     <= 3'd4;
                        r_own_mem <= 1'b0;
                        r_addr    <= if_addr[ADDR_W-1:0];
                    end
                end
                READ: begin
                    // owner dropped its request (e.g. branch flush): abandon silently
                    if (!w_owner_req) begin
                        r_state <= IDLE;
                        r_cnt   <= 3'd0;
                    end else begin
                        r_buf <= w_word;
                        if (r_cnt == r_len) begin
                            r_state <= DONE;
                            r_cnt   <= 3'd0;
                            if (r_own_mem) begin
                                r_mem_rdata <= w_word;
                                r_mem_ready <= 1'b1;
                            end else begin
                                r_if_data  <= w_word;
                                r_if_ready <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 3'd1;
                            if (r_cnt + 3'd1 < r_len)
                                r_addr <= r_addr + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (r_cnt + 3'd1 < r_len) begin
                        r_cnt  <= r_cnt + 3'd1;
                        r_addr <= r_addr + 1'b1;
                        r_dout <= w_next_byte;
                    end else begin
                        r_state     <= DONE;
                        r_cnt       <= 3'd0;
                        r_rw        <= 1'b0;
                        r_mem_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
